// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo timing constants and monitor state type
package servo_pkg;

  localparam int CLK_HZ              = 100_000_000;
  localparam int SERVO_PERIOD_CYCLES = 2_000_000;
  localparam int SERVO_MIN_PULSE     = 50_000;
  localparam int SERVO_MAX_PULSE     = 250_000;

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} pwm_mon_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - two-flop synchroniser plus edge register
// o_s, o_rise and o_fall are mutually aligned: o_rise is high in the first cycle o_s is high.
module pwm_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_din,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_s;
  logic r_rise;
  logic r_fall;

  // Synchroniser is left free-running so a line held high through reset is not seen as a new rise.
  always_ff @(posedge i_clk) begin
    r_meta <= i_din;
    r_sync <= r_meta;
  end

  always_ff @(posedge i_clk) begin
    r_s <= r_sync;
    if (i_reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= r_sync & ~r_s;
      r_fall <= ~r_sync & r_s;
    end
  end

  assign o_s    = r_s;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/servo_pwm_monitor.sv
// rtl/servo_pwm_monitor.sv - measures servo PWM high time and period, flags range and dead line
module servo_pwm_monitor
  import servo_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int MIN_PULSE = SERVO_MIN_PULSE,
  parameter int MAX_PULSE = SERVO_MAX_PULSE,
  parameter int TIMEOUT   = 4_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pwm_in,
  output logic             o_sample_valid,
  output logic [WIDTH-1:0] o_pulse_width,
  output logic [WIDTH-1:0] o_period,
  output logic             o_in_range,
  output logic             o_timeout
);

  localparam logic [WIDTH-1:0] LP_MIN     = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] LP_MAX     = WIDTH'(MAX_PULSE);
  localparam logic [WIDTH-1:0] LP_TIMEOUT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] LP_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic w_s;
  logic w_rise;
  logic w_fall;

  pwm_edge_sync u_edge_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_din   (i_pwm_in),
    .o_s     (w_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  pwm_mon_state_t   r_state;
  pwm_mon_state_t   w_state_nxt;
  logic [WIDTH-1:0] r_hi_cnt;
  logic [WIDTH-1:0] r_per_cnt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_per_nxt;
  logic [WIDTH-1:0] w_hi_inc;
  logic [WIDTH-1:0] w_per_inc;
  logic             w_load;
  logic             w_set_tmo;
  logic             r_sample_valid;
  logic [WIDTH-1:0] r_pulse_width;
  logic [WIDTH-1:0] r_period;
  logic             r_in_range;
  logic             r_timeout;

  assign w_hi_inc  = (&r_hi_cnt)  ? r_hi_cnt  : r_hi_cnt  + LP_ONE;
  assign w_per_inc = (&r_per_cnt) ? r_per_cnt : r_per_cnt + LP_ONE;

  // IDLE also accepts a rise: that rise proves the line was low, and it may land right after a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi_cnt;
    w_per_nxt   = r_per_cnt;
    w_load      = 1'b0;
    w_set_tmo   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_hi_nxt    = LP_ONE;
          w_per_nxt   = LP_ONE;
        end else if (!w_s) begin
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_hi_nxt    = LP_ONE;
          w_per_nxt   = LP_ONE;
        end
      end
      HIGH: begin
        if (r_per_cnt >= LP_TIMEOUT) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_per_nxt = w_per_inc;
          if (w_fall) begin
            w_state_nxt = LOW;
          end else begin
            w_hi_nxt = w_hi_inc;
          end
        end
      end
      LOW: begin
        if (w_rise) begin
          w_load      = 1'b1;
          w_state_nxt = HIGH;
          w_hi_nxt    = LP_ONE;
          w_per_nxt   = LP_ONE;
        end else if (r_per_cnt >= LP_TIMEOUT) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_per_nxt = w_per_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_hi_cnt       <= '0;
      r_per_cnt      <= '0;
      r_sample_valid <= 1'b0;
      r_pulse_width  <= '0;
      r_period       <= '0;
      r_in_range     <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_hi_cnt       <= w_hi_nxt;
      r_per_cnt      <= w_per_nxt;
      r_sample_valid <= w_load;
      if (w_load) begin
        r_pulse_width <= r_hi_cnt;
        r_period      <= r_per_cnt;
        r_in_range    <= (r_hi_cnt >= LP_MIN) && (r_hi_cnt <= LP_MAX);
        r_timeout     <= 1'b0;
      end else if (w_set_tmo) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_sample_valid = r_sample_valid;
  assign o_pulse_width  = r_pulse_width;
  assign o_period       = r_period;
  assign o_in_range     = r_in_range;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_servo_pwm_monitor.sv
// tb/tb_servo_pwm_monitor.sv - randomized self-checking bench for servo_pwm_monitor
module tb_servo_pwm_monitor;

  localparam int W    = 24;
  localparam int MINP = 50;
  localparam int MAXP = 250;
  localparam int T    = 1000;
  localparam int LAT  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwm = 1'b0;
  logic         sv;
  logic [W-1:0] pw;
  logic [W-1:0] per;
  logic         ir;
  logic         tmo;

  servo_pwm_monitor #(
    .WIDTH     (W),
    .MIN_PULSE (MINP),
    .MAX_PULSE (MAXP),
    .TIMEOUT   (T)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_pwm_in       (pwm),
    .o_sample_valid (sv),
    .o_pulse_width  (pw),
    .o_period       (per),
    .o_in_range     (ir),
    .o_timeout      (tmo)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic rst_d = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference: every rise of the line becomes an event LAT cycles later; it closes a period
  // if a previous rise exists and the spacing is within TIMEOUT.
  int ev_k[$];
  bit ev_m[$];
  int ev_pw[$];
  int ev_per[$];
  int prev_c = 0;
  int prev_hi = 0;
  bit have_prev = 1'b0;

  task automatic seg(input bit v, input int n);
    @(posedge clk);
    #1;
    if (v && !pwm) begin
      ev_k.push_back(cyc + LAT);
      ev_m.push_back(have_prev && (cyc - prev_c <= T));
      ev_pw.push_back(prev_hi);
      ev_per.push_back(cyc - prev_c);
      prev_c    = cyc;
      have_prev = 1'b1;
    end else if (!v && pwm) begin
      prev_hi = cyc - prev_c;
    end
    pwm = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    seg(1'b1, hi);
    seg(1'b0, lo);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    have_prev = 1'b0;
    repeat (n - 1) @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int exp_pw = 0;
  int exp_per = 0;
  int exp_ir = 0;
  int exp_tmo = 0;
  int dl = 0;
  bit dl_valid = 1'b0;

  always @(negedge clk) begin
    int exp_sv;
    if (mon_en) begin
      if (rst_d) begin
        exp_pw   = 0;
        exp_per  = 0;
        exp_ir   = 0;
        exp_tmo  = 0;
        dl_valid = 1'b0;
        ev_k.delete();
        ev_m.delete();
        ev_pw.delete();
        ev_per.delete();
        chk("rst_valid", 32'(sv), 0);
        chk("rst_pw", 32'(pw), 0);
        chk("rst_per", 32'(per), 0);
        chk("rst_range", 32'(ir), 0);
        chk("rst_tmo", 32'(tmo), 0);
      end else begin
        exp_sv = 0;
        if (ev_k.size() > 0 && ev_k[0] == cyc) begin
          if (ev_m[0]) begin
            exp_sv  = 1;
            exp_pw  = ev_pw[0];
            exp_per = ev_per[0];
            exp_ir  = (ev_pw[0] >= MINP && ev_pw[0] <= MAXP) ? 1 : 0;
            exp_tmo = 0;
          end
          dl       = cyc + T;
          dl_valid = 1'b1;
          void'(ev_k.pop_front());
          void'(ev_m.pop_front());
          void'(ev_pw.pop_front());
          void'(ev_per.pop_front());
        end else if (dl_valid && cyc == dl) begin
          exp_tmo  = 1;
          dl_valid = 1'b0;
        end
        chk("sample_valid", 32'(sv), 32'(exp_sv));
        chk("pulse_width", 32'(pw), 32'(exp_pw));
        chk("period", 32'(per), 32'(exp_per));
        chk("in_range", 32'(ir), 32'(exp_ir));
        chk("timeout", 32'(tmo), 32'(exp_tmo));
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;

    // Steady waveform: no strobe at the first rise, one per period after.
    seg(1'b0, 20);
    repeat (4) pulse(150, 450);

    // Line held high through reset; the partial pulse must never be reported.
    seg(1'b1, 100);
    do_reset(5);
    seg(1'b1, 60);
    seg(1'b0, 300);
    pulse(120, 400);
    pulse(120, 400);

    // Dead line after a good sample.
    pulse(100, 400);
    pulse(100, 400);
    seg(1'b0, 1500);
    #1;
    chk("dead_tmo", 32'(tmo), 1);
    chk("dead_pw_hold", 32'(pw), 100);
    chk("dead_per_hold", 32'(per), 500);
    pulse(100, 400);
    pulse(100, 400);
    pulse(100, 400);

    // Range boundaries.
    pulse(30, 500);
    pulse(250, 500);
    pulse(251, 500);
    pulse(50, 500);
    pulse(49, 500);
    pulse(100, 400);

    // One-cycle reset mid-HIGH.
    seg(1'b1, 100);
    do_reset(1);
    seg(1'b1, 80);
    seg(1'b0, 200);
    pulse(120, 400);
    pulse(120, 400);

    // Period exactly TIMEOUT (rise wins) and TIMEOUT+1 (timeout, next rise re-arms).
    pulse(100, 900);
    pulse(100, 900);
    pulse(100, 901);
    pulse(100, 400);
    pulse(100, 400);

    for (int i = 0; i < 25; i++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(30, 280));
      lo = int'($urandom_range(2, 1050 - hi));
      pulse(hi, lo);
    end

    seg(1'b1, 10);
    seg(1'b0, 50);
    #1;
    chk("events_drained", 32'(ev_k.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_pwm_monitor.md
# servo_pwm_monitor

Measures the servo control waveform on one pin and reports its high time and period in clock cycles. It closes the loop on the shoulder and elbow PWM generators. One instance per servo line sits beside the controller and feeds verification checks and the LED and debug path. It also flags out-of-range pulse widths and a dead line, so a stalled or misconfigured PWM is visible in hardware.

## Interface
Parameters:
- `WIDTH`, default 24: width of the cycle counters and measurement outputs.
- `MIN_PULSE`, default 50_000: lowest legal high time in cycles (0.5 ms at 100 MHz).
- `MAX_PULSE`, default 250_000: highest legal high time in cycles (2.5 ms).
- `TIMEOUT`, default 4_000_000: cycles with no edge before the line is declared dead (40 ms).

Ports:
- `clk`  in  1: single system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state and outputs.
- `pwm_in`  in  1: servo line under test; asynchronous to `clk`.
- `sample_valid`  out  1: one-cycle strobe; a new measurement is on the outputs.
- `pulse_width`  out  WIDTH: high time of the last complete period, in cycles.
- `period`  out  WIDTH: rise-to-rise time of the last complete period, in cycles.
- `in_range`  out  1: `MIN_PULSE <= pulse_width <= MAX_PULSE` for the current sample.
- `timeout`  out  1: sticky flag for a dead line; cleared by the next `sample_valid` or by `reset`.

## Operation
- `pwm_in` passes through a two-flop synchroniser and then one edge register, giving the synchronised level `s` and one-cycle `rise`/`fall` strobes.
- Two saturating counters, both WIDTH bits: `hi_cnt` and `per_cnt`.
- State IDLE (entered on reset):
  - Wait for `s == 0`, then go to ARM.
  - Purpose: never measure a pulse already in progress at reset.
- State ARM: on `rise`, set `hi_cnt = 1` and `per_cnt = 1`, then go to HIGH.
- State HIGH:
  - Each cycle, increment both counters.
  - On `fall`, freeze `hi_cnt` and go to LOW.
- State LOW:
  - Each cycle, increment `per_cnt`.
  - On `rise`, load `pulse_width <= hi_cnt` and `period <= per_cnt`, and register `in_range` from `hi_cnt`.
  - In the same cycle, pulse `sample_valid`, clear `timeout`, restart both counters at 1, and go to HIGH.
- Result: a high level lasting exactly N cycles of `s` with a rise-to-rise spacing of P cycles reports `pulse_width = N` and `period = P` exactly.
- Timeout:
  - In HIGH or LOW, if `per_cnt` reaches `TIMEOUT` with no closing `rise`, set `timeout = 1` and go to IDLE.
  - `pulse_width`, `period` and `in_range` hold their last values.
- Counters saturate at all-ones and never wrap. With `TIMEOUT < 2^WIDTH` saturation is unreachable, but it is still required.
- Simultaneous events: `rise` and the timeout terminal count in the same cycle resolve as `rise`. The sample is emitted and `timeout` is not set.
- Reset mid-operation:
  - All outputs return to 0 on the next edge.
  - State returns to IDLE, so the first new sample needs a full fresh period.
- A high pulse shorter than `MIN_PULSE` is still reported, with `in_range = 0`; it is not filtered.

## Timing
- Reset values: `sample_valid`, `pulse_width`, `period`, `in_range` and `timeout` are all 0. State is IDLE and both counters are 0.
- Latency: `sample_valid` asserts on the 3rd rising `clk` edge after the edge at which `pwm_in` is first sampled high for the closing rise. That is 2 synchroniser stages plus 1 output register.
- `pulse_width`, `period` and `in_range` change only in the cycle `sample_valid` is high, and are stable until the next strobe.
- Throughput: at most one sample per `pwm_in` period. The minimum legal period is 2 cycles high plus 2 cycles low, so at least 4 cycles apart.
- `timeout` rises exactly `TIMEOUT` cycles after the last `rise` seen in HIGH or LOW.

## Structure
- Shared package `servo_pkg` holds:
  - `CLK_HZ`.
  - `SERVO_PERIOD_CYCLES` (2_000_000).
  - `SERVO_MIN_PULSE` / `SERVO_MAX_PULSE`, used as the parameter defaults here and reused by the PWM generators.
  - `typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} pwm_mon_state_t`.
- One sub-module, `pwm_edge_sync`: two-flop synchroniser plus edge register. Outputs `s`, `rise` and `fall`; reusable for the ultrasonic echo input.

## Test plan
- Reset, then a 150_000-cycle high / 2_000_000-cycle period waveform.
  - No strobe at the first rise.
  - First `sample_valid` arrives 3 cycles after the second rise, with `pulse_width = 150000`, `period = 2000000`, `in_range = 1`.
  - Exactly one strobe per period after that.
- `pwm_in` held high through reset release: IDLE waits for low; the first strobe needs two later rises, and the partial pulse is never reported.
- With `TIMEOUT = 1000`: after one good sample, hold `pwm_in` low. `timeout = 1` exactly 1000 cycles after the last rise, the earlier values hold, and the next two rises clear `timeout` and strobe.
- 30_000-cycle high pulse: reported `pulse_width = 30000`, `in_range = 0`. A 250_000-cycle high pulse gives `in_range = 1` (inclusive bound).
- `reset` pulsed for one cycle mid-HIGH: all outputs are 0 on the next cycle, and no strobe occurs until a full new period completes.
- Closing rise in the same cycle as the timeout terminal count: `sample_valid = 1` and `timeout` stays 0.
